// File: rtl/gl_pkg.sv
// Shared definitions for the Grunwald-Letnikov operator datapath.
//  - GL_DATA_W / GL_FRAC_W : Q8.24 result format produced by the operator stage
//  - clog2                 : constant-friendly ceiling log2
//  - shift_sat             : arithmetic (floor) right shift followed by a
//                            saturation to a signed out_w-bit range
package gl_pkg;

    localparam int GL_DATA_W = 32;
    localparam int GL_FRAC_W = 24;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Floor-shift v right by sh, then clamp to [-2^(out_w-1), 2^(out_w-1)-1].
    function automatic logic signed [63:0] shift_sat(input logic signed [63:0] v,
                                                     input int unsigned       sh,
                                                     input int unsigned       out_w);
        logic signed [63:0] t;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        t  = v >>> sh;
        hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 32'd1));
        if (t > hi) begin
            return hi;
        end else if (t < lo) begin
            return lo;
        end else begin
            return t;
        end
    endfunction

endpackage

// File: rtl/gl_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//  clk, rst      : clock, synchronous active-low reset
//  wr_en_i/wr_data_i : write request; ignored when full unless a read
//                      happens in the same cycle
//  rd_en_i       : read (pop) request; ignored when empty
//  rd_data_o     : head entry, zero while empty
//  empty_o/full_o/level_o : occupancy status
module gl_sync_fifo
    import gl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en_i,
    input  logic [WIDTH-1:0]               wr_data_i,
    input  logic                           rd_en_i,
    output logic [WIDTH-1:0]               rd_data_o,
    output logic                           empty_o,
    output logic                           full_o,
    output logic [clog2(DEPTH+1)-1:0]      level_o
);

    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam int LVL_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             wr_ok_s, rd_ok_s, empty_s, full_s;

    assign empty_s = (count_q == LVL_W'(0));
    assign full_s  = (count_q == LVL_W'(DEPTH));
    // A pop frees the slot the concurrent push needs, so full + pop still writes.
    assign rd_ok_s = rd_en_i && !empty_s;
    assign wr_ok_s = wr_en_i && (!full_s || rd_ok_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= LVL_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk) begin
        if (rst && wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_s ? WIDTH'(0) : mem_q[rd_ptr_q];
    assign empty_o   = empty_s;
    assign full_o    = full_s;
    assign level_o   = count_q;

endmodule

// File: rtl/gl_result_decimator.sv
// Decimating output stage for the Grunwald-Letnikov operator.
// Captures each Q8.24 result flagged by a change of in_tog, averages DECIM
// consecutive results, converts the average to a saturated Q(OUT_W-OUT_FRAC).OUT_FRAC
// word and queues it in a FWFT FIFO drained over a valid/ready stream.
//  clk, rst   : clock, synchronous active-low reset
//  in_data    : signed operator result; in_tog : toggles once per new result
//  out_data/out_valid/out_ready : output stream (FIFO head)
//  level      : FIFO occupancy
//  overflow   : sticky "result dropped on full FIFO"; clr_ovf clears it
module gl_result_decimator
    import gl_pkg::*;
#(
    parameter int DATA_W   = GL_DATA_W,
    parameter int FRAC_W   = GL_FRAC_W,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 12,
    parameter int DECIM    = 4,
    parameter int DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic                          in_tog,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [clog2(DEPTH+1)-1:0]     level,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int          LOG2D    = clog2(DECIM);
    localparam int          ACC_W    = DATA_W + LOG2D;
    localparam int          CNT_W    = (LOG2D > 0) ? LOG2D : 1;
    localparam int          LVL_W    = clog2(DEPTH + 1);
    // Averaging and format change fold into one floor shift.
    localparam int unsigned SHIFT    = LOG2D + FRAC_W - OUT_FRAC;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic                    tog_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] res_q, res_d;
    logic                    pend_q, pend_d;
    logic                    ovf_q, ovf_d;
    logic                    accept_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    fifo_empty_s, fifo_full_s, pop_s, drop_s;
    logic [OUT_W-1:0]        fifo_rd_data_s;
    logic [LVL_W-1:0]        fifo_level_s;

    assign accept_s = (in_tog != tog_q);
    assign sum_s    = acc_q + ACC_W'(in_data);
    assign pop_s    = !fifo_empty_s && out_ready;
    assign drop_s   = pend_q && fifo_full_s && !pop_s;

    // Accumulator / block counter; the closing sample restarts the block in the same edge.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        pend_d = 1'b0;
        if (accept_s) begin
            if (cnt_q == CNT_LAST) begin
                acc_d  = ACC_W'(0);
                cnt_d  = CNT_W'(0);
                res_d  = OUT_W'(shift_sat(64'(sum_s), SHIFT, OUT_W));
                pend_d = 1'b1;
            end else begin
                acc_d  = sum_s;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Datapath registers; tog_q follows in_tog even in reset so release never fakes an accept.
    always_ff @(posedge clk) begin
        tog_q <= in_tog;
        if (!rst) begin
            acc_q  <= ACC_W'(0);
            cnt_q  <= CNT_W'(0);
            res_q  <= OUT_W'(0);
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    gl_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (pend_q),
        .wr_data_i (res_q),
        .rd_en_i   (out_ready),
        .rd_data_o (fifo_rd_data_s),
        .empty_o   (fifo_empty_s),
        .full_o    (fifo_full_s),
        .level_o   (fifo_level_s)
    );

    assign out_data  = fifo_rd_data_s;
    assign out_valid = !fifo_empty_s;
    assign level     = fifo_level_s;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_gl_result_decimator.sv
// Self-checking bench for gl_result_decimator (default parameters:
// DECIM=4, Q8.24 in, Q4.12 out, 16-entry FIFO).
module tb_gl_result_decimator;

    logic        clk = 1'b0;
    logic        rst, in_tog, out_ready, clr_ovf;
    logic [31:0] in_data;
    logic [15:0] out_data;
    logic        out_valid, overflow;
    logic [4:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gl_result_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_tog    (in_tog),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    typedef struct {
        logic [3:0][31:0] s;
        logic [15:0]      exp;
        string            nm;
    } vec_t;

    vec_t        vecs[9];
    logic [15:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d);
        in_data = d;
        in_tog  = ~in_tog;
        step();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: average of four Q8.24 samples re-expressed in Q4.12 is
    // floor(sum / (4 * 2^12)), clamped to the 16-bit signed range.
    function automatic logic [15:0] model(input longint sum);
        longint q;
        q = longint'($floor(real'(sum) / 16384.0));
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    function automatic vec_t mk(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d, input logic [15:0] e);
        vec_t v;
        v.nm  = nm;
        v.s   = {d, c, b, a};
        v.exp = e;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint macc;
        int     nacc;
        logic   exp_v, tg;
        int     r;

        vecs[0] = mk("one",      32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 16'h1000);
        vecs[1] = mk("prec",     32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0080_0000, 16'h0E00);
        vecs[2] = mk("neg_lsb",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF);
        vecs[3] = mk("sat_pos",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'h7FFF);
        vecs[4] = mk("sat_neg",  32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 16'h8000);
        vecs[5] = mk("neg_1p5",  32'hFE80_0000, 32'hFE80_0000, 32'hFE80_0000, 32'hFE80_0000, 16'hE800);
        vecs[6] = mk("sub_lsb",  32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF, 16'h0000);
        vecs[7] = mk("one_lsb",  32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 16'h0001);
        vecs[8] = mk("mix",      32'h0700_0000, 32'h0700_0000, 32'h0880_0000, 32'h0880_0000, 16'h7C00);

        rst = 1'b0; in_tog = 1'b0; in_data = 32'h0; out_ready = 1'b0; clr_ovf = 1'b0;

        // T1: reset while toggling, then exactly four accepts produce one push
        for (int i = 0; i < 3; i++) begin
            in_tog = ~in_tog;
            step();
        end
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) put(32'h0100_0000);
        step(); step(); step();
        chk("t1_no_early_push", 32'(level), 32'd0);
        put(32'h0100_0000);
        chk("t1_latency_e0", 32'(out_valid), 32'd0);
        step();
        chk("t1_latency_e1", 32'(out_valid), 32'd1);
        chk("t1_level", 32'(level), 32'd1);
        chk("t1_data", 32'(out_data), 32'h1000);
        out_ready = 1'b1;
        step();
        chk("t1_popped", 32'(level), 32'd0);

        // T2: continuous toggling, valid one edge after every 4th accept
        for (int e = 1; e <= 16; e++) begin
            if (e <= 12) put(32'h0100_0000);
            else step();
            exp_v = (e >= 5) && (e <= 13) && (e % 4 == 1);
            chk("t2_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) chk("t2_data", 32'(out_data), 32'h1000);
        end

        // T3/T4 and more: table of four-sample blocks
        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < 4; k++) put(vecs[v].s[k]);
            for (int k = 0; k < 4 && !out_valid; k++) step();
            chk({"tbl_valid_", vecs[v].nm}, 32'(out_valid), 32'd1);
            chk({"tbl_data_", vecs[v].nm}, 32'(out_data), 32'(vecs[v].exp));
            step();
        end

        // T5: backpressure, overflow, full push+pop, drain order, clear
        out_ready = 1'b0;
        for (int b = 1; b <= 17; b++)
            for (int k = 0; k < 4; k++) put(32'(b) << 22);
        step(); step();
        chk("t5_level_full", 32'(level), 32'd16);
        chk("t5_ovf_set", 32'(overflow), 32'd1);
        chk("t5_head", 32'(out_data), 32'h0400);
        for (int k = 0; k < 4; k++) put(32'd18 << 22);
        out_ready = 1'b1;
        chk("t5_pop_head", 32'(out_data), 32'h0400);
        step();
        out_ready = 1'b0;
        chk("t5_level_pushpop", 32'(level), 32'd16);
        chk("t5_ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t5_drain_valid", 32'(out_valid), 32'd1);
            chk("t5_drain_data", 32'(out_data), (i < 15) ? 32'((i + 2) * 32'h400) : 32'(18 * 32'h400));
            step();
        end
        chk("t5_empty", 32'(level), 32'd0);
        chk("t5_ovf_hold", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t5_ovf_clr", 32'(overflow), 32'd0);

        // T6: reset mid-block discards the partial accumulation
        out_ready = 1'b0;
        put(32'h0500_0000);
        put(32'h0500_0000);
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) put(32'h0100_0000);
        step(); step();
        chk("t6_level", 32'(level), 32'd1);
        chk("t6_data", 32'(out_data), 32'h1000);
        out_ready = 1'b1;
        step();
        step(); step();
        chk("t6_single", 32'(level), 32'd0);

        // Random traffic against the reference model
        macc = 0;
        nacc = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            tg = ($urandom_range(0, 3) != 0);
            if (tg) begin
                r = $urandom;
                in_data = ($urandom_range(0, 1) != 0) ? 32'(r) : 32'(r >>> 6);
                in_tog = ~in_tog;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rnd_extra: got %h expected no output", out_data);
                end else begin
                    chk("rnd_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            if (tg) begin
                macc += longint'(int'(in_data));
                nacc++;
                if (nacc == 4) begin
                    exp_q.push_back(model(macc));
                    macc = 0;
                    nacc = 0;
                end
            end
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rnd_extra: got %h expected no output", out_data);
                end else begin
                    chk("rnd_drain", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            step();
        end
        chk("rnd_missing", 32'(exp_q.size()), 32'd0);
        chk("rnd_level", 32'(level), 32'd0);
        chk("rnd_ovf", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
